// File: rtl/cla_slice_sequencer.sv
// Streams a wide addition through a 16-bit, four-group lookahead-carry adder, one slice per beat.
// The slice carry is registered and chained into the next slice; one output register decouples the two streams.
module cla_slice_sequencer #(
  parameter int MAX_SLICES = 8,
  parameter int IDX_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic [IDX_W-1:0] out_idx,
  output logic             err_overlen,
  input  logic             err_clr
);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       RUN      = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SLICES - 1);

  function automatic logic nib_g(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] g;
    p = a | b;
    g = a & b;
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  function automatic logic nib_p(input logic [3:0] a, input logic [3:0] b);
    return &(a | b);
  endfunction

  function automatic logic [3:0] nib_sum(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [3:0] s;
    logic       cy;
    cy = c;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | ((a[i] | b[i]) & cy);
    end
    return s;
  endfunction

  logic [0:0]       state_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;
  logic             out_valid_r;
  logic [15:0]      sum_r;
  logic             last_r;
  logic             cout_r;
  logic [IDX_W-1:0] out_idx_r;
  logic             err_r;

  logic             c0_s, c1_s, c2_s, c3_s;
  logic [3:0]       gb_s, pb_s, g_s, p_s;
  logic             gbo_s, pbo_s, cout_s;
  logic [15:0]      sum_s;
  logic             in_ready_s, accept_s, last_eff_s, overlen_s;

  assign in_ready_s = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready_s;
  assign last_eff_s = in_last || (idx_r == LAST_IDX);
  assign overlen_s  = accept_s && (idx_r == LAST_IDX) && !in_last;

  // Group generate/propagate (active-low into the lookahead stage), 74182 carries and slice sum.
  always_comb begin
    if (state_r == RUN) begin
      c0_s = carry_r;
    end else begin
      c0_s = cin;
    end
    for (int k = 0; k < 4; k++) begin
      gb_s[k] = ~nib_g(in_a[4*k +: 4], in_b[4*k +: 4]);
      pb_s[k] = ~nib_p(in_a[4*k +: 4], in_b[4*k +: 4]);
    end
    g_s   = ~gb_s;
    p_s   = ~pb_s;
    c1_s  = g_s[0] | (p_s[0] & c0_s);
    c2_s  = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c0_s);
    c3_s  = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0]) | (p_s[2] & p_s[1] & p_s[0] & c0_s);
    gbo_s = ~(g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1]) | (p_s[3] & p_s[2] & p_s[1] & g_s[0]));
    pbo_s = ~(&p_s);
    cout_s = ~gbo_s | (~pbo_s & c0_s);
    sum_s = {nib_sum(in_a[15:12], in_b[15:12], c3_s), nib_sum(in_a[11:8], in_b[11:8], c2_s),
             nib_sum(in_a[7:4], in_b[7:4], c1_s), nib_sum(in_a[3:0], in_b[3:0], c0_s)};
  end

  // Operation sequencing: state, slice index, chained carry and the sticky overlength flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        case (state_r)
          IDLE:    state_r <= last_eff_s ? IDLE : RUN;
          RUN:     state_r <= last_eff_s ? IDLE : RUN;
          default: state_r <= IDLE;
        endcase
        idx_r   <= last_eff_s ? '0 : idx_r + IDX_W'(1);
        carry_r <= last_eff_s ? 1'b0 : cout_s;
      end
      if (overlen_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end
    end
  end

  // Output register: loads on accept, holds under backpressure, empties when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= 16'h0000;
      last_r      <= 1'b0;
      cout_r      <= 1'b0;
      out_idx_r   <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      sum_r       <= sum_s;
      last_r      <= last_eff_s;
      cout_r      <= cout_s;
      out_idx_r   <= idx_r;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_sum     = sum_r;
  assign out_last    = last_r;
  assign out_cout    = cout_r;
  assign out_idx     = out_idx_r;
  assign err_overlen = err_r;

endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
- Sequences a wide addition through one 16-bit, four-group lookahead-carry stage (74182 convention), one 16-bit slice per accepted beat.
- Carry out of each slice is registered and chained into the next slice.
- Streaming valid/ready on both sides; a single output register decouples producer and consumer.
- Sits between an operand-fetch stream and the result writer in the arithmetic datapath.

Parameters:
- MAX_SLICES, 8, maximum slices per operation; a slice at index MAX_SLICES-1 is forced to be last.
- IDX_W, 3, width of the slice index; must satisfy 2^IDX_W >= MAX_SLICES.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cin  input  1  carry-in for the operation; sampled only with the first slice.
- in_valid  input  1  operand slice valid.
- in_ready  output  1  slice accepted when in_valid && in_ready.
- in_a  input  16  operand A slice, LSB slice first.
- in_b  input  16  operand B slice.
- in_last  input  1  marks the final slice of the operation.
- out_valid  output  1  result slice valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_sum  output  16  sum slice.
- out_last  output  1  final slice of the operation.
- out_cout  output  1  carry out of this slice; the operation carry when out_last=1.
- out_idx  output  IDX_W  slice index within the operation, 0-based.
- err_overlen  output  1  sticky; set when a slice is force-terminated.
- err_clr  input  1  synchronous clear of err_overlen.

Behaviour:
- Reset (async): state=IDLE, carry_q=0, idx_q=0; out_valid=0, out_sum=0, out_last=0, out_cout=0, out_idx=0, err_overlen=0.
- in_ready = !out_valid || out_ready (combinational). A new slice can be accepted in the same cycle the held result drains.
- Carry source: cin in IDLE, carry_q in RUN.
- Per slice, per bit: p=a|b, g=a&b.
- Per nibble k: Gk = g3|p3g2|p3p2g1|p3p2p1g0; Pk = p0&p1&p2&p3.
- Pass to the lookahead stage active-low: PB[k]=~Pk, GB[k]=~Gk.
- Nibble carries follow 74182 equations: c1=G0|P0c0; c2=G1|P1G0|P1P0c0; c3=G2|P2G1|P2P1G0|P2P1P0c0.
- Slice carry out = Gtot|Ptot&c0, with Gtot/Ptot taken from the GBo/PBo equivalents.
- Result requirement: {out_cout,out_sum} == in_a+in_b+carry, bit-exact (17-bit).
- Latency: one cycle from acceptance to out_valid=1. Output register holds while out_valid && !out_ready.
- State machine:
  - IDLE -> RUN on accept with effective last=0.
  - IDLE stays IDLE on accept with effective last=1.
  - RUN -> IDLE on accept with effective last=1.
  - No accept: state unchanged.
- Effective last = in_last || (idx_q == MAX_SLICES-1).
- On accept:
  - out_idx <= idx_q.
  - idx_q <= last ? 0 : idx_q+1.
  - carry_q <= last ? 0 : slice cout.
  - out_last <= effective last.
- err_overlen is set when idx_q==MAX_SLICES-1, in_last=0, and a slice is accepted. If err_clr and a set event occur in the same cycle, set wins.
- Single-slice operation (IDLE with in_last=1): uses cin; returns to IDLE; out_idx=0.
- Reset mid-operation: in-flight result and carry are discarded; the next slice is treated as first.
- in_a, in_b, in_last and cin are don't-care when in_valid=0.

Test Plan:
- Single slice: A=0xFFFF, B=0x0001, cin=0, last=1 -> out_sum=0x0000, out_cout=1, out_last=1, out_idx=0, next cycle.
- Three-slice chain: A={0x0000,0xFFFF,0xFFFF}, B={0,0,1} (MSB..LSB), cin=0 -> sums 0x0000,0x0000,0x0001; couts 1,1,0; idx 0,1,2; out_last only on idx 2.
- Backpressure: out_ready=0 for 4 cycles with a second slice pending -> in_ready=0, out_sum stable, no slice lost. Releasing out_ready accepts the next slice in the same cycle.
- Overlength, MAX_SLICES=8: 9 slices with in_last=0 -> slice 7 has out_last=1 and err_overlen=1; slice 8 restarts with idx 0 using cin. err_clr clears the flag.
- Reset mid-op: assert rst after slice 1 of 3 -> outputs zero immediately. Next slice A=0x7FFF, B=0x0000, cin=1 -> 0x8000, cout=0, idx 0.
- Random: 10k operations of 1..8 slices with random stalls -> concatenated result equals the wide reference sum plus cin.
